// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the receive, transmit and com_block paths.
package uart_pkg;
    localparam int OVERSAMPLE = 8;
    localparam int START_MID = 4;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word fall-through FIFO; reused by the RX and TX paths.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_wr, do_rd;

    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign do_wr = wr_en && (!full || do_rd);
    assign drop = wr_en && full && !do_rd;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= do_wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_rd ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 8x oversampling feeding a receive FIFO with sticky error flags.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int CLK_DIV = 13,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          err_clr,
    output logic                          irq
);
    localparam int TW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    rx_state_t state, next_state;
    logic rx_meta, rx_sync;
    logic [TW-1:0] tick_cnt;
    logic [2:0] phase, bit_cnt;
    logic [7:0] shift;
    logic tick, start_det, mid, bit_end;
    logic push, frame_evt, phase_clr, sample, drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick = tick_cnt == TW'(CLK_DIV - 1);
    assign start_det = state == IDLE && !rx_sync;
    assign mid = tick && phase == 3'(START_MID - 1);
    assign bit_end = tick && phase == 3'(OVERSAMPLE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = rx_sync ? IDLE : START;
            START:     next_state = !mid ? START : rx_sync ? IDLE : DATA;
            DATA:      next_state = bit_end && bit_cnt == 3'd7 ? STOP : DATA;
            STOP:      next_state = !bit_end ? STOP : rx_sync ? IDLE : WAIT_HIGH;
            WAIT_HIGH: next_state = rx_sync ? IDLE : WAIT_HIGH;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        push = state == STOP && bit_end && rx_sync;
        frame_evt = state == STOP && bit_end && !rx_sync;
        phase_clr = start_det || (state == START && mid);
        sample = state == DATA && bit_end;
    end

    // Ticks are re-aligned to the start edge so mid-bit sampling tracks the sender.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            phase <= '0;
            bit_cnt <= '0;
            shift <= '0;
        end else begin
            tick_cnt <= (start_det || tick) ? '0 : tick_cnt + TW'(1);
            phase <= phase_clr ? 3'd0 : tick ? phase + 3'd1 : phase;
            bit_cnt <= phase_clr ? 3'd0 : sample ? bit_cnt + 3'd1 : bit_cnt;
            shift <= sample ? {rx_sync, shift[7:1]} : shift;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(push),
        .wr_data(shift),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .empty(empty),
        .full(full),
        .count(count),
        .drop(drop)
    );

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow <= drop || (overflow && !err_clr);
            frame_err <= frame_evt || (frame_err && !err_clr);
        end
    end

    assign irq = !empty;
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 13: clk cycles per oversample tick (8 ticks per bit; 1 MHz mclk gives 9615 baud).
REQ-002 Parameter FIFO_DEPTH, default 8: receive FIFO entries; power of two, 2..64.
REQ-003 Port clk  in  1  single clock (mclk domain); all state on rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port rx  in  1  UART serial input, asynchronous, idle high.
REQ-006 Port rd_en  in  1  pop head byte (from com_block read of UART data register).
REQ-007 Port rd_data  out  8  head byte, first-word fall-through.
REQ-008 Port empty / full  out  1 each  FIFO status.
REQ-009 Port count  out  clog2(FIFO_DEPTH)+1  bytes held.
REQ-010 Port overflow / frame_err  out  1 each  sticky error flags.
REQ-011 Port err_clr  in  1  clears both sticky flags.
REQ-012 Port irq  out  1  receive interrupt to com_block, = ~empty.

Function
REQ-013 rx SHALL pass a 2-FF synchronizer; only the synchronized value is used.
REQ-014 Tick counter SHALL count 0..CLK_DIV-1 and assert tick for one clk when it reaches CLK_DIV-1; it free-runs except when reset to 0 on start-edge detection.
REQ-015 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: synchronized rx low -> START, reset tick and phase counters.
REQ-017 START: at 4th tick (mid-bit) rx low -> DATA; rx high -> IDLE (glitch, no error).
REQ-018 DATA: sample every 8 ticks, LSB first, 8 bits into shift register, then -> STOP.
REQ-019 STOP: sample after 8 ticks; rx high -> push byte, -> IDLE; rx low -> set frame_err, discard byte, -> WAIT_HIGH.
REQ-020 WAIT_HIGH: stay until synchronized rx high, then -> IDLE (break does not retrigger).
REQ-021 Push latency: empty SHALL deassert and rd_data show the byte 1 clk after the stop-sample tick.
REQ-022 rd_en with empty=0 SHALL pop the head; rd_en with empty=1 SHALL be ignored (no pointer move, no error).
REQ-023 Push when full without same-cycle pop: byte dropped, overflow set, contents unchanged.
REQ-024 Push and pop same cycle: both occur, count unchanged; when full this SHALL NOT set overflow.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; full when count==FIFO_DEPTH.
REQ-026 err_clr SHALL clear flags next clk; an error event in the same cycle as err_clr wins (flag stays set).

Reset
REQ-027 rst_n low SHALL immediately force: FSM IDLE, counters 0, FIFO emptied, rd_data 8'h00, empty 1, full 0, count 0, overflow 0, frame_err 0, irq 0; synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL abort the frame with no partial byte pushed; reception resumes on the next falling edge after release.

Structure
REQ-029 Shared uart_pkg SHALL hold the FSM state enum, OVERSAMPLE=8 and START_MID=4; com_block and a future uart_tx import it.
REQ-030 FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH), reusable by the TX path.

Verification
REQ-031 Send 0x55 at 104 clk/bit -> rd_data 0x55, empty 0, irq 1 within 1 clk of stop sample; rd_en -> empty 1.
REQ-032 Send 0x01..0x09 without reads -> full after 8th, overflow 1 after 9th; reads return 0x01..0x08 in order.
REQ-033 Stop bit driven low on 0xA3 -> frame_err 1, count 0; rx high, then 0x3C -> received correctly.
REQ-034 30-clk low glitch on idle rx -> no byte, no error, FSM back in IDLE.
REQ-035 rst_n low at bit 4 of 0xF0 -> all outputs at reset values; next frame 0x0F received intact.
REQ-036 FIFO full, rd_en pulse at the same cycle as a push -> count stays 8, overflow 0, err_clr with concurrent overflow event -> overflow remains 1.
